// File: rtl/led_arb_sched_if.sv
// Bundles the LED ownership request/grant signals and the prescaler
// observation outputs of led_arb_sched.
interface led_arb_sched_if;
  logic [2:0]  req;
  logic [2:0]  grant;
  logic        led_out;
  logic [24:0] cnt;
  logic        tick;

  modport master (output req, input grant, led_out, cnt, tick);
  modport slave  (input req, output grant, led_out, cnt, tick);
endinterface

// File: rtl/led_arb_sched.sv
// Shared-LED arbiter: the owner picked by fixed priority keeps the LED for a
// whole 8-tick frame and drives its own blink pattern; re-arbitration happens only at frame ends.
module led_arb_sched #(
  parameter logic [24:0] CNT_MAX = 25'd24_999_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  led_arb_sched_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [24:0] cnt_q, cnt_next;
  logic [2:0]  phase, phase_next;
  logic [2:0]  grant_q, grant_next;
  logic        tick_int;
  logic        frame_end;
  logic        led;

  function automatic logic [2:0] pick(input logic [2:0] r);
    if (r[2])      return 3'b100;
    else if (r[1]) return 3'b010;
    else if (r[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      cnt_q   <= '0;
      phase   <= '0;
      grant_q <= '0;
    end else begin
      state   <= state_next;
      cnt_q   <= cnt_next;
      phase   <= phase_next;
      grant_q <= grant_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt_q;
    phase_next = phase;
    grant_next = grant_q;
    tick_int   = (state == RUN) && (cnt_q == CNT_MAX);
    frame_end  = tick_int && (phase == 3'd7);
    case (state)
      IDLE: begin
        cnt_next   = '0;
        phase_next = '0;
        grant_next = '0;
        if (bus.req != 3'b000) begin
          grant_next = pick(bus.req);
          state_next = RUN;
        end
      end
      RUN: begin
        cnt_next = tick_int ? 25'd0 : cnt_q + 25'd1;
        if (tick_int) phase_next = phase + 3'd1;
        // Requests are only sampled here, so mid-frame changes never preempt or shorten a frame.
        if (frame_end) begin
          if (bus.req != 3'b000) begin
            grant_next = pick(bus.req);
          end else begin
            state_next = IDLE;
            grant_next = '0;
            cnt_next   = '0;
            phase_next = '0;
          end
        end
      end
    endcase
  end

  always_comb begin
    led = 1'b0;
    case (grant_q)
      3'b100:  led = ~phase[0];
      3'b010:  led = ~phase[2];
      3'b001:  led = (phase == 3'd0);
      default: led = 1'b0;
    endcase
  end

  assign bus.grant   = grant_q;
  assign bus.cnt     = cnt_q;
  assign bus.tick    = tick_int;
  assign bus.led_out = led;

endmodule

// File: tb/tb_led_arb_sched.sv
// Self-checking bench for led_arb_sched: directed scenarios plus random
// request bursts, all checked against a frame-position reference model.
module tb_led_arb_sched;

  localparam int CNT_MAX = 4;
  localparam int TICK    = CNT_MAX + 1;
  localparam int FRAME   = 8 * TICK;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks    = 0;
  int   failures  = 0;

  led_arb_sched_if bus_i ();

  led_arb_sched #(.CNT_MAX(25'(CNT_MAX))) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_i)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: whether a frame is running, position within the frame, and the owner index.
  bit m_run   = 1'b0;
  int m_k     = 0;
  int m_owner = 0;

  function automatic int prio(input logic [2:0] r);
    if (r[2]) return 2;
    if (r[1]) return 1;
    return 0;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_run   <= 1'b0;
      m_k     <= 0;
      m_owner <= 0;
    end else if (!m_run) begin
      if (bus_i.req != 3'b000) begin
        m_run   <= 1'b1;
        m_k     <= 0;
        m_owner <= prio(bus_i.req);
      end
    end else if (m_k == FRAME - 1) begin
      m_k <= 0;
      if (bus_i.req != 3'b000) m_owner <= prio(bus_i.req);
      else                     m_run   <= 1'b0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  function automatic logic [31:0] exp_grant();
    return m_run ? (32'd1 << m_owner) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_cnt();
    return m_run ? 32'(m_k % TICK) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_tick();
    return (m_run && (m_k % TICK == TICK - 1)) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] exp_led();
    int ph;
    ph = m_k / TICK;
    if (!m_run)       return 32'd0;
    if (m_owner == 2) return (ph % 2 == 0) ? 32'd1 : 32'd0;
    if (m_owner == 1) return (ph < 4) ? 32'd1 : 32'd0;
    return (ph == 0) ? 32'd1 : 32'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("grant", 32'(bus_i.grant), exp_grant());
    checkOutput("cnt", 32'(bus_i.cnt), exp_cnt());
    checkOutput("tick", 32'(bus_i.tick), exp_tick());
    checkOutput("led_out", 32'(bus_i.led_out), exp_led());
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_grant"}, 32'(bus_i.grant), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(bus_i.cnt), 32'd0);
    checkOutput({tag, "_tick"}, 32'(bus_i.tick), 32'd0);
    checkOutput({tag, "_led"}, 32'(bus_i.led_out), 32'd0);
  endtask

  // Each cycle: check outputs on the falling edge, then present the new request.
  task automatic applyStimulus(input logic [2:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      checkAll();
      bus_i.req = r;
    end
  endtask

  task automatic resetMidFrame(input int target_k, input logic [2:0] r_after);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge sys_clk);
      checkAll();
      if (m_run && m_k == target_k) found = 1'b1;
    end
    checkOutput("reach_frame_pos", 32'(found), 32'd1);
    #1 sys_rst_n = 1'b0;
    #1 checkAllZero("async_rst");
    bus_i.req = r_after;
    @(negedge sys_clk);
    checkAllZero("in_rst");
    sys_rst_n = 1'b1;
  endtask

  initial begin
    bus_i.req = 3'b111;
    sys_rst_n = 1'b0;
    #10 checkAllZero("rst_a");
    #8  checkAllZero("rst_b");
    bus_i.req = 3'b000;
    #2  sys_rst_n = 1'b1;

    applyStimulus(3'b000, 3);
    applyStimulus(3'b001, 12);
    applyStimulus(3'b011, 44);
    applyStimulus(3'b000, 45);
    applyStimulus(3'b111, 1);
    applyStimulus(3'b000, 45);
    applyStimulus(3'b010, 5);
    resetMidFrame(27, 3'b010);
    applyStimulus(3'b010, 45);

    for (int b = 0; b < 40; b++) begin
      applyStimulus(3'($urandom_range(0, 7)), int'($urandom_range(1, 30)));
    end
    applyStimulus(3'b000, FRAME + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
